mem_bus_master: RTL and testbench

- Initiator side of the shared single-port memory bus (wr/rd strobes, address, bidirectional tristate data).
- Accepts single-beat writes and incrementing read bursts on a valid/ready command interface.
- Sequences the memory strobes and owns the master side of the inout data bus, guaranteeing no drive contention.
- Returns read data on a valid/ready response interface; sits between the CPU/controller datapath and the memory.

---
 rtl/mem_bus_pkg.sv | 22 ++
 rtl/mem_bus_master.sv | 140 ++++++++++++++
 tb/tb_mem_bus_master.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the single-port memory bus: master FSM state
// encoding and default bus geometry, also used by the memory block.
package mem_bus_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_RSP   = 3'd3;
  localparam logic [2:0] S_TURN  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_WRITE = S_WRITE,
    ST_READ  = S_READ,
    ST_RSP   = S_RSP,
    ST_TURN  = S_TURN
  } state_e;

endpackage

// File: rtl/mem_bus_master.sv
// Initiator for the shared single-port memory bus: single-beat writes and
// incrementing read bursts, with strobes decoded from the state register only.
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int LEN_W    = 3,
  parameter int TURN_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [LEN_W-1:0]  req_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_last,
  output logic              wr_done,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data
);

  state_e            r_state;
  state_e            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [LEN_W-1:0]  r_count;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rsp_valid;
  logic              r_rsp_last;
  logic              r_wr_done;
  logic              w_accept;
  logic              w_rsp_accept;
  logic              w_turn_en;
  logic              w_last_beat;

  assign w_turn_en    = (TURN_CYC != 0);
  assign w_accept     = req_valid && (r_state == ST_IDLE);
  assign w_rsp_accept = rsp_ready && r_rsp_valid && (r_state == ST_RSP);
  assign w_last_beat  = (r_count == {LEN_W{1'b0}});

  assign req_ready = (r_state == ST_IDLE);
  assign mem_wr    = (r_state == ST_WRITE);
  assign mem_rd    = (r_state == ST_READ);
  assign mem_addr  = r_addr;
  // Only the WRITE state may drive the bus, so the memory's read driver never overlaps ours
  assign mem_data  = mem_wr ? r_wdata : {DATA_W{1'bz}};

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign rsp_last  = r_rsp_last;
  assign wr_done   = r_wr_done;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (req_we) w_next = ST_WRITE;
          else        w_next = ST_READ;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (w_turn_en) w_next = ST_TURN;
        else           w_next = ST_IDLE;
      end
      ST_READ: w_next = ST_RSP;
      ST_RSP: begin
        if (!w_rsp_accept)     w_next = ST_RSP;
        else if (!w_last_beat) w_next = ST_READ;
        else if (w_turn_en)    w_next = ST_TURN;
        else                   w_next = ST_IDLE;
      end
      ST_TURN: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Command capture, burst address/count and response registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr      <= {ADDR_W{1'b0}};
      r_wdata     <= {DATA_W{1'b0}};
      r_count     <= {LEN_W{1'b0}};
      r_rdata     <= {DATA_W{1'b0}};
      r_rsp_valid <= 1'b0;
      r_rsp_last  <= 1'b0;
      r_wr_done   <= 1'b0;
    end else begin
      r_wr_done <= (r_state == ST_WRITE);
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_count <= req_we ? {LEN_W{1'b0}} : req_len;
          end
        end
        ST_READ: begin
          r_rdata     <= mem_data;
          r_rsp_valid <= 1'b1;
          r_rsp_last  <= w_last_beat;
        end
        ST_RSP: begin
          if (w_rsp_accept) begin
            r_rsp_valid <= 1'b0;
            r_rsp_last  <= 1'b0;
            // Address wraps naturally at the top of the space
            if (!w_last_beat) begin
              r_count <= r_count - LEN_W'(1);
              r_addr  <= r_addr + ADDR_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed and constrained-random bench for mem_bus_master against a
// behavioural single-port memory sharing the tristate data bus.
module tb_mem_bus_master;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [LW-1:0] req_len = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_last;
  logic          wr_done;
  logic          mem_wr;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  wire  [DW-1:0] mem_data;

  logic [DW-1:0] mem     [0:31];
  logic [DW-1:0] ref_mem [0:31];
  logic [DW-1:0] exp_data_q [$];
  logic          exp_last_q [$];

  int n_vec = 0;
  int n_err = 0;
  int n_conflict = 0;
  int n_wr_cyc = 0;
  int n_rsp_cyc = 0;
  int snap;

  mem_bus_master #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .TURN_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_last(rsp_last), .wr_done(wr_done),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read drive, write on the strobed edge
  assign mem_data = mem_rd ? mem[mem_addr] : {DW{1'bz}};
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_data;
  end

  // Bus monitors sampled mid-cycle
  always @(negedge clk) begin
    if ((mem_wr && mem_rd) || (mem_wr && $isunknown(mem_data))) n_conflict <= n_conflict + 1;
    if (mem_wr)    n_wr_cyc  <= n_wr_cyc + 1;
    if (rsp_valid) n_rsp_cyc <= n_rsp_cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    chk("wr_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; req_len = LW'($urandom);
    ref_mem[a] = d;
    tick();
    req_valid = 1'b0; req_we = 1'b0;
    chk("wr_mem_wr", 32'(mem_wr), 32'd1);
    chk("wr_mem_rd", 32'(mem_rd), 32'd0);
    chk("wr_addr", 32'(mem_addr), 32'(a));
    chk("wr_data", 32'(mem_data), 32'(d));
    chk("wr_done_early", 32'(wr_done), 32'd0);
    tick();
    chk("wr_done", 32'(wr_done), 32'd1);
    chk("wr_turn_wr", 32'(mem_wr), 32'd0);
    chk("wr_turn_rd", 32'(mem_rd), 32'd0);
    chk("wr_turn_ready", 32'(req_ready), 32'd0);
    tick();
    chk("wr_done_clr", 32'(wr_done), 32'd0);
    chk("wr_idle_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [LW-1:0] len,
                         input int stall_beat, input int stall_n);
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    chk("rd_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_len = len; req_wdata = DW'($urandom);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      ea = a + AW'(i);
      ed = ref_mem[ea];
      chk("rd_mem_rd", 32'(mem_rd), 32'd1);
      chk("rd_mem_wr", 32'(mem_wr), 32'd0);
      chk("rd_addr", 32'(mem_addr), 32'(ea));
      chk("rd_valid_low", 32'(rsp_valid), 32'd0);
      tick();
      chk("rd_valid", 32'(rsp_valid), 32'd1);
      chk("rd_data", 32'(rsp_rdata), 32'(ed));
      chk("rd_last", 32'(rsp_last), 32'(i == int'(len)));
      chk("rsp_mem_rd", 32'(mem_rd), 32'd0);
      if (i == stall_beat) begin
        for (int s = 0; s < stall_n; s++) begin
          tick();
          chk("stall_valid", 32'(rsp_valid), 32'd1);
          chk("stall_data", 32'(rsp_rdata), 32'(ed));
          chk("stall_mem_rd", 32'(mem_rd), 32'd0);
          chk("stall_addr", 32'(mem_addr), 32'(ea));
        end
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end
    chk("rd_turn_rd", 32'(mem_rd), 32'd0);
    chk("rd_turn_wr", 32'(mem_wr), 32'd0);
    chk("rd_turn_valid", 32'(rsp_valid), 32'd0);
    chk("rd_turn_ready", 32'(req_ready), 32'd0);
    tick();
    chk("rd_idle_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    // Reset values
    tick();
    tick();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_last", 32'(rsp_last), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_wr_done", 32'(wr_done), 32'd0);
    rst_n = 1'b1;
    tick();

    // Known contents everywhere
    for (int a = 0; a < 32; a++) do_write(AW'(a), DW'(a * 7 + 3));

    // Write then read back a single word
    snap = n_wr_cyc;
    do_write(5'd5, 8'hA5);
    chk("wr_one_cycle", 32'(n_wr_cyc - snap), 32'd1);
    do_read(5'd5, 3'd0, -1, 0);

    // Wrapping burst, then with a stall on beat 2
    do_write(5'd30, 8'h11);
    do_write(5'd31, 8'h22);
    do_write(5'd0,  8'h33);
    do_write(5'd1,  8'h44);
    do_read(5'd30, 3'd3, -1, 0);
    do_read(5'd30, 3'd3, 1, 3);

    // Write right after a read; the turn cycle is checked at the end of do_read
    do_write(5'd12, 8'h5C);
    do_read(5'd12, 3'd0, -1, 0);

    // Reset during beat 2 of an 8-beat burst
    req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd10; req_len = 3'd7;
    tick();
    req_valid = 1'b0;
    tick();
    chk("pre_rst_data", 32'(rsp_rdata), 32'(ref_mem[10]));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("mid_rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_rsp_last", 32'(rsp_last), 32'd0);
    chk("mid_rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("mid_rst_wr_done", 32'(wr_done), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    snap = n_rsp_cyc;
    repeat (6) tick();
    chk("post_rst_no_beats", 32'(n_rsp_cyc - snap), 32'd0);

    // Random commands with req_valid held, scoreboarded against ref_mem
    for (int c = 0; c < 200; c++) begin
      req_valid = 1'b1;
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = AW'($urandom);
      req_wdata = DW'($urandom);
      req_len   = LW'($urandom);
      rsp_ready = 1'($urandom_range(0, 1));
      if (req_ready) begin
        if (req_we) begin
          ref_mem[req_addr] = req_wdata;
        end else begin
          for (int j = 0; j <= int'(req_len); j++) begin
            exp_data_q.push_back(ref_mem[req_addr + AW'(j)]);
            exp_last_q.push_back(j == int'(req_len));
          end
        end
      end
      if (rsp_valid && rsp_ready) begin
        chk("sb_pending", 32'(exp_data_q.size() > 0), 32'd1);
        if (exp_data_q.size() > 0) begin
          chk("sb_data", 32'(rsp_rdata), 32'(exp_data_q.pop_front()));
          chk("sb_last", 32'(rsp_last), 32'(exp_last_q.pop_front()));
        end
      end
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (rsp_valid) begin
        chk("drain_pending", 32'(exp_data_q.size() > 0), 32'd1);
        if (exp_data_q.size() > 0) begin
          chk("drain_data", 32'(rsp_rdata), 32'(exp_data_q.pop_front()));
          chk("drain_last", 32'(rsp_last), 32'(exp_last_q.pop_front()));
        end
      end
      tick();
    end
    rsp_ready = 1'b0;
    chk("sb_drained", 32'(exp_data_q.size()), 32'd0);
    chk("final_idle", 32'(req_ready), 32'd1);
    chk("no_strobe_overlap", 32'(n_conflict), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
